convolve_weight_loader: RTL

Streams a full set of 3x3-channel convolution kernel weights in over a 9-bit AXI-Stream slave and drives the flat packed `weight_i` bus of `convolve_rgb`. Incoming words fill a shadow register. The shadow register is copied to the active output only at a frame boundary, so the kernel never changes mid-frame. The block sits between the control/DMA path and the convolution stage.

---
 rtl/convolve_pkg.sv | 33 +++
 rtl/convolve_weight_loader.sv | 99 +++++++++
 2 files changed

// File: rtl/convolve_pkg.sv
// convolve_pkg: shared definitions for the convolution path.
//   weight_count(k)         - number of 9-bit weights for a K x K, 3-in/3-out kernel
//   identity_weights(k, rs) - packed identity kernel (1<<rs at centre taps where out == in),
//                             returned in a MAX_W-wide vector; callers keep the low 9*N bits
//   loader_state_t          - weight loader FSM states
package convolve_pkg;

  localparam int MAX_K = 7;
  localparam int MAX_W = 9 * 9 * MAX_K * MAX_K;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } loader_state_t;

  function automatic int weight_count(input int k);
    return 9 * k * k;
  endfunction

  // Word n = ((out*3 + in)*K + i)*K + j sits at bits [9n+8:9n].
  function automatic logic [MAX_W-1:0] identity_weights(input int k, input int rs);
    logic [MAX_W-1:0] v;
    int n;
    v = '0;
    for (int c = 0; c < 3; c++) begin
      n = ((c * 3 + c) * k + k / 2) * k + k / 2;
      v[9*n +: 9] = 9'(1 << rs);
    end
    return v;
  endfunction

endpackage

// File: rtl/convolve_weight_loader.sv
// convolve_weight_loader: AXI-Stream loader for convolve_rgb kernel weights.
// Words stream into a shadow array; the complete set is copied to the active
// register only on frame_done_i, so the kernel never changes mid-frame.
// Ports:
//   clock_i, reset_ni         - clock, async active-low reset
//   s_weight_tvalid_i/tready_o/tdata_i/tlast_i - 9-bit signed weight stream
//   frame_done_i              - end-of-frame pulse, commit point
//   weight_o                  - active weights, 9*N bits, word n at [9n+8:9n]
//   weight_updated_o          - one-cycle pulse following a commit
//   error_o                   - sticky framing error, cleared by a well-framed set
module convolve_weight_loader
  import convolve_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int RIGHT_SHIFT = 2
) (
  input  logic                                      clock_i,
  input  logic                                      reset_ni,
  input  logic                                      s_weight_tvalid_i,
  output logic                                      s_weight_tready_o,
  input  logic [8:0]                                s_weight_tdata_i,
  input  logic                                      s_weight_tlast_i,
  input  logic                                      frame_done_i,
  output logic [9*weight_count(KERNEL_SIZE)-1:0]    weight_o,
  output logic                                      weight_updated_o,
  output logic                                      error_o
);

  localparam int N  = weight_count(KERNEL_SIZE);
  localparam int W  = 9 * N;
  localparam int CW = $clog2(N);
  localparam logic [MAX_W-1:0] ID_FULL = identity_weights(KERNEL_SIZE, RIGHT_SHIFT);
  localparam logic [W-1:0]     ID_W    = ID_FULL[W-1:0];
  localparam logic [CW-1:0]    LAST_IDX = CW'(N - 1);

  loader_state_t state;
  logic [CW-1:0] count;
  logic [8:0]    shadow [N];
  logic          accept;

  // Ready is a pure decode of registered state: no path from tvalid.
  assign s_weight_tready_o = (state != PENDING);
  assign accept            = s_weight_tvalid_i & s_weight_tready_o;

  // Shadow contents are don't-care after reset, so no reset here.
  always_ff @(posedge clock_i) begin
    if (accept && state == LOAD) shadow[count] <= s_weight_tdata_i;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state            <= LOAD;
      count            <= '0;
      weight_o         <= ID_W;
      weight_updated_o <= 1'b0;
      error_o          <= 1'b0;
    end else begin
      weight_updated_o <= 1'b0;
      unique case (state)
        LOAD: begin
          if (accept) begin
            if (count == LAST_IDX) begin
              count <= '0;
              if (s_weight_tlast_i) begin
                state   <= PENDING;
                error_o <= 1'b0;
              end else begin
                // Set is too long: swallow the rest up to tlast.
                state   <= DRAIN;
                error_o <= 1'b1;
              end
            end else if (s_weight_tlast_i) begin
              // Short set: discard and restart at word 0.
              count   <= '0;
              error_o <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        PENDING: begin
          if (frame_done_i) begin
            for (int n = 0; n < N; n++) weight_o[9*n +: 9] <= shadow[n];
            weight_updated_o <= 1'b1;
            state            <= LOAD;
          end
        end
        DRAIN: begin
          if (accept && s_weight_tlast_i) begin
            state <= LOAD;
            count <= '0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
